// File: rtl/rv32i_pkg.sv
// Shared rv32i encodings: ALUOp codes, internal ALU operation set, branch funct3 codes
// and the ALU-control decode used by the execute stage.
package rv32i_pkg;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_op_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // I-type ignores funct7 for funct3=000 since bit 30 belongs to the immediate there
   function automatic alu_op_e alu_decode(input logic [1:0] aluop,
                                          input logic [2:0] funct3,
                                          input logic       funct7_5);
      alu_op_e op;
      op = ALU_ADD;
      case (aluop)
         ALUOP_ADD:    op = ALU_ADD;
         ALUOP_BRANCH: op = ALU_SUB;
         default: begin
            case (funct3)
               3'b000:  op = (aluop == ALUOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  op = ALU_SLL;
               3'b010:  op = ALU_SLT;
               3'b011:  op = ALU_SLTU;
               3'b100:  op = ALU_XOR;
               3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational rv32i ALU; arithmetic wraps modulo 2^XLEN, shifts use b[4:0].
module ex_alu
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// rv32i execute stage: operand forwarding, ALU control, ALU, branch resolution
// and the EX/MEM pipeline register with stall/bubble handling.
module ex_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            combined_stall,
   input  logic [XLEN-1:0] ID_EX_PC,
   input  logic [XLEN-1:0] ID_EX_ReadData1,
   input  logic [XLEN-1:0] ID_EX_ReadData2,
   input  logic [XLEN-1:0] ID_EX_Immediate,
   input  logic [4:0]      ID_EX_Rs1,
   input  logic [4:0]      ID_EX_Rs2,
   input  logic [4:0]      ID_EX_Rd,
   input  logic [6:0]      ID_EX_Funct7,
   input  logic [2:0]      ID_EX_Funct3,
   input  logic            ID_EX_ALUSrc,
   input  logic [1:0]      ID_EX_ALUOp,
   input  logic            ID_EX_Branch,
   input  logic            ID_EX_MemRead,
   input  logic            ID_EX_MemWrite,
   input  logic            ID_EX_MemtoReg,
   input  logic            ID_EX_RegWrite,
   input  logic            ID_EX_enable_out,
   input  logic            MEM_WB_RegWrite,
   input  logic [4:0]      MEM_WB_Rd,
   input  logic [XLEN-1:0] MEM_WB_WriteData,
   output logic [XLEN-1:0] EX_MEM_ALUResult,
   output logic [XLEN-1:0] EX_MEM_WriteData,
   output logic [4:0]      EX_MEM_Rd,
   output logic [2:0]      EX_MEM_Funct3,
   output logic            EX_MEM_MemRead,
   output logic            EX_MEM_MemWrite,
   output logic            EX_MEM_MemtoReg,
   output logic            EX_MEM_RegWrite,
   output logic            EX_MEM_BranchTaken,
   output logic [XLEN-1:0] EX_MEM_BranchTarget,
   output logic            EX_MEM_enable_out,
   output logic            ex_branch_taken,
   output logic [XLEN-1:0] ex_branch_target
);

   logic            ex_fwd_ok;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   alu_op_e         alu_op;
   logic            branch_cond;
   logic            unused_funct7;

   assign unused_funct7 = ^{ID_EX_Funct7[6], ID_EX_Funct7[4:0]};

   // A load in EX/MEM has no data yet; the hazard unit stalls for that case
   assign ex_fwd_ok = EX_MEM_enable_out & EX_MEM_RegWrite & ~EX_MEM_MemRead & (EX_MEM_Rd != '0);

   always_comb begin
      fwd_a = ID_EX_ReadData1;
      if (ex_fwd_ok && EX_MEM_Rd == ID_EX_Rs1)
         fwd_a = EX_MEM_ALUResult;
      else if (MEM_WB_RegWrite && MEM_WB_Rd != '0 && MEM_WB_Rd == ID_EX_Rs1)
         fwd_a = MEM_WB_WriteData;
   end

   always_comb begin
      fwd_b = ID_EX_ReadData2;
      if (ex_fwd_ok && EX_MEM_Rd == ID_EX_Rs2)
         fwd_b = EX_MEM_ALUResult;
      else if (MEM_WB_RegWrite && MEM_WB_Rd != '0 && MEM_WB_Rd == ID_EX_Rs2)
         fwd_b = MEM_WB_WriteData;
   end

   assign alu_b  = ID_EX_ALUSrc ? ID_EX_Immediate : fwd_b;
   assign alu_op = alu_decode(ID_EX_ALUOp, ID_EX_Funct3, ID_EX_Funct7[5]);

   ex_alu #(
      .XLEN(XLEN)
   ) u_alu (
      .op    (alu_op),
      .a     (fwd_a),
      .b     (alu_b),
      .result(alu_result),
      .zero  (alu_zero)
   );

   // Branches decode to SUB on register operands, so the ALU zero flag is the equality test
   always_comb begin
      branch_cond = 1'b0;
      case (ID_EX_Funct3)
         F3_BEQ:  branch_cond = alu_zero;
         F3_BNE:  branch_cond = ~alu_zero;
         F3_BLT:  branch_cond = $signed(fwd_a) <  $signed(fwd_b);
         F3_BGE:  branch_cond = $signed(fwd_a) >= $signed(fwd_b);
         F3_BLTU: branch_cond = fwd_a <  fwd_b;
         F3_BGEU: branch_cond = fwd_a >= fwd_b;
         default: branch_cond = 1'b0;
      endcase
   end

   assign ex_branch_target = ID_EX_PC + ID_EX_Immediate;
   assign ex_branch_taken  = ID_EX_enable_out & ID_EX_Branch & branch_cond & ~combined_stall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         EX_MEM_ALUResult    <= '0;
         EX_MEM_WriteData    <= '0;
         EX_MEM_Rd           <= '0;
         EX_MEM_Funct3       <= '0;
         EX_MEM_MemRead      <= 1'b0;
         EX_MEM_MemWrite     <= 1'b0;
         EX_MEM_MemtoReg     <= 1'b0;
         EX_MEM_RegWrite     <= 1'b0;
         EX_MEM_BranchTaken  <= 1'b0;
         EX_MEM_BranchTarget <= '0;
         EX_MEM_enable_out   <= 1'b0;
      end else if (!combined_stall) begin
         if (ID_EX_enable_out) begin
            EX_MEM_ALUResult    <= alu_result;
            EX_MEM_WriteData    <= fwd_b;
            EX_MEM_Rd           <= ID_EX_Rd;
            EX_MEM_Funct3       <= ID_EX_Funct3;
            EX_MEM_MemRead      <= ID_EX_MemRead;
            EX_MEM_MemWrite     <= ID_EX_MemWrite;
            EX_MEM_MemtoReg     <= ID_EX_MemtoReg;
            EX_MEM_RegWrite     <= ID_EX_RegWrite;
            EX_MEM_BranchTaken  <= ID_EX_Branch & branch_cond;
            EX_MEM_BranchTarget <= ex_branch_target;
            EX_MEM_enable_out   <= 1'b1;
         end else begin
            EX_MEM_MemRead      <= 1'b0;
            EX_MEM_MemWrite     <= 1'b0;
            EX_MEM_RegWrite     <= 1'b0;
            EX_MEM_BranchTaken  <= 1'b0;
            EX_MEM_enable_out   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, branches, stall, bubble and async reset.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        combined_stall;
   logic [31:0] ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Immediate;
   logic [4:0]  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
   logic [6:0]  ID_EX_Funct7;
   logic [2:0]  ID_EX_Funct3;
   logic        ID_EX_ALUSrc;
   logic [1:0]  ID_EX_ALUOp;
   logic        ID_EX_Branch, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_RegWrite;
   logic        ID_EX_enable_out;
   logic        MEM_WB_RegWrite;
   logic [4:0]  MEM_WB_Rd;
   logic [31:0] MEM_WB_WriteData;
   logic [31:0] EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_BranchTarget, ex_branch_target;
   logic [4:0]  EX_MEM_Rd;
   logic [2:0]  EX_MEM_Funct3;
   logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg, EX_MEM_RegWrite;
   logic        EX_MEM_BranchTaken, EX_MEM_enable_out, ex_branch_taken;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .combined_stall(combined_stall),
      .ID_EX_PC(ID_EX_PC), .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
      .ID_EX_Immediate(ID_EX_Immediate), .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2),
      .ID_EX_Rd(ID_EX_Rd), .ID_EX_Funct7(ID_EX_Funct7), .ID_EX_Funct3(ID_EX_Funct3),
      .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_Branch(ID_EX_Branch),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
      .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_RegWrite(ID_EX_RegWrite),
      .ID_EX_enable_out(ID_EX_enable_out), .MEM_WB_RegWrite(MEM_WB_RegWrite),
      .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_WriteData(MEM_WB_WriteData),
      .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_WriteData(EX_MEM_WriteData),
      .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_Funct3(EX_MEM_Funct3), .EX_MEM_MemRead(EX_MEM_MemRead),
      .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
      .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_BranchTaken(EX_MEM_BranchTaken),
      .EX_MEM_BranchTarget(EX_MEM_BranchTarget), .EX_MEM_enable_out(EX_MEM_enable_out),
      .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Default to a plain valid ADD of x0-sourced operands with no hazards
   task automatic clear_inputs();
      ID_EX_PC = '0; ID_EX_ReadData1 = '0; ID_EX_ReadData2 = '0; ID_EX_Immediate = '0;
      ID_EX_Rs1 = '0; ID_EX_Rs2 = '0; ID_EX_Rd = '0; ID_EX_Funct7 = '0; ID_EX_Funct3 = '0;
      ID_EX_ALUSrc = 1'b0; ID_EX_ALUOp = 2'b00; ID_EX_Branch = 1'b0; ID_EX_MemRead = 1'b0;
      ID_EX_MemWrite = 1'b0; ID_EX_MemtoReg = 1'b0; ID_EX_RegWrite = 1'b0;
      ID_EX_enable_out = 1'b1; MEM_WB_RegWrite = 1'b0; MEM_WB_Rd = '0; MEM_WB_WriteData = '0;
   endtask

   task automatic addi(input logic [4:0] rs1, input logic [31:0] rd1,
                       input logic [31:0] imm, input logic [4:0] rd);
      clear_inputs();
      ID_EX_Rs1 = rs1; ID_EX_ReadData1 = rd1; ID_EX_Immediate = imm; ID_EX_Rd = rd;
      ID_EX_ALUSrc = 1'b1; ID_EX_ALUOp = 2'b11; ID_EX_RegWrite = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_alu"}, EX_MEM_ALUResult, 32'h0);
      check({tag, "_wdata"}, EX_MEM_WriteData, 32'h0);
      check({tag, "_btgt"}, EX_MEM_BranchTarget, 32'h0);
      check({tag, "_ctl"}, {16'h0, EX_MEM_Rd, EX_MEM_Funct3, EX_MEM_MemRead, EX_MEM_MemWrite,
                             EX_MEM_MemtoReg, EX_MEM_RegWrite, EX_MEM_BranchTaken,
                             EX_MEM_enable_out, 2'b00}, 32'h0);
   endtask

   typedef struct {
      logic [1:0]  aluop;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        alusrc;
      logic [31:0] b;
      logic [31:0] exp;
   } alu_vec_t;

   // a = 0xF0000008 for every row
   alu_vec_t alu_tab[13] = '{
      '{2'b10, 3'b000, 7'h00, 1'b0, 32'h4,  32'hF000000C},
      '{2'b10, 3'b000, 7'h20, 1'b0, 32'h4,  32'hF0000004},
      '{2'b10, 3'b001, 7'h00, 1'b0, 32'h4,  32'h00000080},
      '{2'b10, 3'b001, 7'h00, 1'b0, 32'h24, 32'h00000080},
      '{2'b10, 3'b010, 7'h00, 1'b0, 32'h4,  32'h00000001},
      '{2'b10, 3'b011, 7'h00, 1'b0, 32'h4,  32'h00000000},
      '{2'b10, 3'b100, 7'h00, 1'b0, 32'h4,  32'hF000000C},
      '{2'b10, 3'b101, 7'h00, 1'b0, 32'h4,  32'h0F000000},
      '{2'b10, 3'b101, 7'h20, 1'b0, 32'h4,  32'hFF000000},
      '{2'b10, 3'b110, 7'h00, 1'b0, 32'h4,  32'hF000000C},
      '{2'b10, 3'b111, 7'h00, 1'b0, 32'h4,  32'h00000000},
      '{2'b11, 3'b000, 7'h20, 1'b1, 32'h4,  32'hF000000C},
      '{2'b11, 3'b101, 7'h20, 1'b1, 32'h4,  32'hFF000000}
   };

   logic [2:0] br_f3[8]  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
   logic       br_exp[8] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};

   initial begin
      clear_inputs();
      combined_stall = 1'b0;
      reset_n = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // R-type SUB 10 - 3
      clear_inputs();
      ID_EX_Rs1 = 5'd1; ID_EX_ReadData1 = 32'd10; ID_EX_Rs2 = 5'd2; ID_EX_ReadData2 = 32'd3;
      ID_EX_Rd = 5'd5; ID_EX_RegWrite = 1'b1; ID_EX_ALUOp = 2'b10; ID_EX_Funct7 = 7'h20;
      tick();
      check("sub_result", EX_MEM_ALUResult, 32'd7);
      check("sub_valid", {31'h0, EX_MEM_enable_out}, 32'h1);
      check("sub_rd", {27'h0, EX_MEM_Rd}, 32'd5);

      foreach (alu_tab[i]) begin
         clear_inputs();
         ID_EX_Rd = 5'd1; ID_EX_RegWrite = 1'b1; ID_EX_ReadData1 = 32'hF0000008;
         ID_EX_ALUOp = alu_tab[i].aluop; ID_EX_Funct3 = alu_tab[i].f3;
         ID_EX_Funct7 = alu_tab[i].f7; ID_EX_ALUSrc = alu_tab[i].alusrc;
         if (alu_tab[i].alusrc) ID_EX_Immediate = alu_tab[i].b;
         else ID_EX_ReadData2 = alu_tab[i].b;
         tick();
         check($sformatf("alu_row%0d", i), EX_MEM_ALUResult, alu_tab[i].exp);
      end

      // EX/MEM -> EX forwarding
      addi(5'd0, 32'h0, 32'h100, 5'd5);
      tick();
      addi(5'd5, 32'h0, 32'h4, 5'd6);
      tick();
      check("fwd_exmem", EX_MEM_ALUResult, 32'h104);

      // EX/MEM holds a load, so MEM/WB must be used instead
      addi(5'd0, 32'h200, 32'h0, 5'd5);
      ID_EX_ALUOp = 2'b00; ID_EX_MemRead = 1'b1;
      tick();
      check("load_memread", {31'h0, EX_MEM_MemRead}, 32'h1);
      addi(5'd5, 32'h0, 32'h4, 5'd6);
      MEM_WB_RegWrite = 1'b1; MEM_WB_Rd = 5'd5; MEM_WB_WriteData = 32'h20;
      tick();
      check("fwd_memwb_past_load", EX_MEM_ALUResult, 32'h24);

      // Double hazard on store data: EX/MEM wins
      addi(5'd0, 32'h0, 32'h1, 5'd7);
      tick();
      clear_inputs();
      ID_EX_Rs1 = 5'd0; ID_EX_ReadData1 = 32'h80; ID_EX_Rs2 = 5'd7; ID_EX_ReadData2 = 32'hDEAD;
      ID_EX_Immediate = 32'h8; ID_EX_ALUSrc = 1'b1; ID_EX_MemWrite = 1'b1; ID_EX_Funct3 = 3'b010;
      MEM_WB_RegWrite = 1'b1; MEM_WB_Rd = 5'd7; MEM_WB_WriteData = 32'h2;
      tick();
      check("store_wdata", EX_MEM_WriteData, 32'h1);
      check("store_addr", EX_MEM_ALUResult, 32'h88);
      check("store_ctl", {27'h0, EX_MEM_Funct3, EX_MEM_MemWrite, EX_MEM_RegWrite}, 32'h0000000A);

      // Rd = x0 passes through but is never forwarded
      addi(5'd0, 32'h55, 32'h0, 5'd0);
      tick();
      check("rd0_pass", {26'h0, EX_MEM_Rd, EX_MEM_RegWrite}, 32'h1);
      addi(5'd0, 32'h11, 32'h0, 5'd3);
      tick();
      check("rd0_nofwd", EX_MEM_ALUResult, 32'h11);

      // BLT / BLTU with -1 vs 1
      clear_inputs();
      ID_EX_Rs1 = 5'd10; ID_EX_ReadData1 = 32'hFFFFFFFF; ID_EX_Rs2 = 5'd11; ID_EX_ReadData2 = 32'h1;
      ID_EX_PC = 32'h40; ID_EX_Immediate = 32'h10; ID_EX_Branch = 1'b1; ID_EX_ALUOp = 2'b01;
      ID_EX_Funct3 = 3'b100;
      #1;
      check("blt_taken", {31'h0, ex_branch_taken}, 32'h1);
      check("blt_target", ex_branch_target, 32'h50);
      tick();
      check("blt_reg", {31'h0, EX_MEM_BranchTaken}, 32'h1);
      check("blt_reg_tgt", EX_MEM_BranchTarget, 32'h50);
      ID_EX_Funct3 = 3'b110;
      #1;
      check("bltu_taken", {31'h0, ex_branch_taken}, 32'h0);
      tick();
      check("bltu_reg", {31'h0, EX_MEM_BranchTaken}, 32'h0);

      // Equal operands across every funct3
      foreach (br_f3[i]) begin
         clear_inputs();
         ID_EX_Rs1 = 5'd12; ID_EX_ReadData1 = 32'h5; ID_EX_Rs2 = 5'd13; ID_EX_ReadData2 = 32'h5;
         ID_EX_Branch = 1'b1; ID_EX_ALUOp = 2'b01; ID_EX_Funct3 = br_f3[i];
         #1;
         check($sformatf("br_eq_f3_%0d", br_f3[i]), {31'h0, ex_branch_taken}, {31'h0, br_exp[i]});
      end
      tick();

      // Stall freezes EX/MEM and blocks the redirect
      addi(5'd0, 32'h33, 32'h0, 5'd9);
      tick();
      check("pre_stall", EX_MEM_ALUResult, 32'h33);
      combined_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         ID_EX_Rs1 = 5'd12; ID_EX_ReadData1 = 32'h7 + i; ID_EX_ReadData2 = 32'h7 + i;
         ID_EX_Rs2 = 5'd13; ID_EX_Branch = 1'b1; ID_EX_ALUOp = 2'b01; ID_EX_Rd = 5'd20;
         #1;
         check($sformatf("stall_redirect%0d", i), {31'h0, ex_branch_taken}, 32'h0);
         tick();
         check($sformatf("stall_hold%0d", i), {EX_MEM_ALUResult[23:0], 2'b0, EX_MEM_Rd, EX_MEM_enable_out},
               {24'h000033, 2'b0, 5'd9, 1'b1});
      end
      combined_stall = 1'b0;
      addi(5'd0, 32'h44, 32'h0, 5'd10);
      tick();
      check("post_stall", EX_MEM_ALUResult, 32'h44);

      // Bubble: control cleared, data fields held
      clear_inputs();
      ID_EX_enable_out = 1'b0; ID_EX_MemWrite = 1'b1; ID_EX_RegWrite = 1'b1;
      ID_EX_ReadData1 = 32'h99; ID_EX_Rd = 5'd15;
      tick();
      check("bubble_ctl", {29'h0, EX_MEM_enable_out, EX_MEM_MemWrite, EX_MEM_RegWrite}, 32'h0);
      check("bubble_hold", {EX_MEM_ALUResult[26:0], EX_MEM_Rd}, {27'h44, 5'd10});

      // Asynchronous reset between edges
      addi(5'd0, 32'h1234, 32'h0, 5'd4);
      ID_EX_MemRead = 1'b1; ID_EX_MemtoReg = 1'b1;
      tick();
      check("pre_reset", EX_MEM_ALUResult, 32'h1234);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
